// File: rtl/address_sequencer.sv
// address_sequencer: pops command words from a first-word-fall-through FIFO
// and issues registered address/data write beats under valid/ready.
// A command word is either a single write (explicit address) or a burst
// header announcing len+1 data words written to auto-incremented addresses.
module address_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int ADDR_STEP  = 1,
    parameter int FIFO_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [FIFO_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  busy_o
);

    typedef enum logic {
        ST_CMD,
        ST_BURST
    } state_t;

    // Registered state
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr_cnt;
    logic [LEN_WIDTH:0]    r_rem;
    logic                  r_wr_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    // Next-state values
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_cnt_nxt;
    logic [LEN_WIDTH:0]    w_rem_nxt;
    logic                  w_wr_valid_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_last_nxt;

    // Fields of the head FIFO word
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [DATA_WIDTH-1:0] w_word_data;
    logic                  w_word_flag;
    logic [LEN_WIDTH:0]    w_burst_beats;
    logic                  w_free;
    logic                  w_pop;
    logic                  w_rem_is_one;

    assign w_word_addr = fifo_data_i[ADDR_WIDTH-1:0];
    assign w_word_data = fifo_data_i[ADDR_WIDTH +: DATA_WIDTH];
    assign w_word_flag = fifo_data_i[FIFO_WIDTH-1];

    // One extra bit so an all-ones length field yields 2^LEN_WIDTH beats.
    assign w_burst_beats = {1'b0, w_word_data[LEN_WIDTH-1:0]} + (LEN_WIDTH+1)'(1);
    assign w_rem_is_one  = (r_rem == (LEN_WIDTH+1)'(1));

    // The output slot can take a new beat when empty or draining this cycle.
    assign w_free = !r_wr_valid || wr_ready_i;
    // Gated by rst_ni so nothing is consumed while the block is held in reset.
    assign w_pop  = rst_ni && enable_i && !fifo_empty_i && w_free;

    assign fifo_rd_en_o = w_pop;
    assign wr_valid_o   = r_wr_valid;
    assign addr_o       = r_addr;
    assign data_o       = r_data;
    assign last_o       = r_last;
    assign busy_o       = (r_state == ST_BURST) || r_wr_valid;

    // Next-state and next-output decode for the CMD/BURST machine.
    always_comb begin
        // NOTE: every output of this block is given a hold value first, so no
        // path through the branches below can leave a signal unassigned and
        // infer a latch.
        w_state_nxt    = r_state;
        w_addr_cnt_nxt = r_addr_cnt;
        w_rem_nxt      = r_rem;
        w_wr_valid_nxt = r_wr_valid;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_last_nxt     = r_last;

        if (w_pop) begin
            unique case (r_state)
                ST_CMD: begin
                    if (w_word_flag) begin
                        // Burst header: arm the counters, issue no beat.
                        w_addr_cnt_nxt = w_word_addr;
                        w_rem_nxt      = w_burst_beats;
                        w_wr_valid_nxt = 1'b0;
                        w_last_nxt     = 1'b0;
                        w_state_nxt    = ST_BURST;
                    end else begin
                        // Single write with an explicit address.
                        w_addr_nxt     = w_word_addr;
                        w_data_nxt     = w_word_data;
                        w_last_nxt     = 1'b1;
                        w_wr_valid_nxt = 1'b1;
                    end
                end
                ST_BURST: begin
                    // Burst data word: flag and address fields are ignored.
                    w_addr_nxt     = r_addr_cnt;
                    w_data_nxt     = w_word_data;
                    w_last_nxt     = w_rem_is_one;
                    w_wr_valid_nxt = 1'b1;
                    w_addr_cnt_nxt = r_addr_cnt + ADDR_WIDTH'(ADDR_STEP);
                    w_rem_nxt      = r_rem - (LEN_WIDTH+1)'(1);
                    if (w_rem_is_one) begin
                        w_state_nxt = ST_CMD;
                    end
                end
                default: begin
                    w_state_nxt = ST_CMD;
                end
            endcase
        end else if (r_wr_valid && wr_ready_i) begin
            // Beat accepted with nothing to replace it.
            w_wr_valid_nxt = 1'b0;
            w_last_nxt     = 1'b0;
        end
    end

    // State register and registered output stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_CMD;
            r_addr_cnt <= '0;
            r_rem      <= '0;
            r_wr_valid <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            r_state    <= w_state_nxt;
            r_addr_cnt <= w_addr_cnt_nxt;
            r_rem      <= w_rem_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_last     <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_address_sequencer.sv
// Randomized self-checking bench for address_sequencer. The expected beat for
// every FIFO word is derived when the command stream is generated, straight
// from the command semantics (single = one beat, header = len+1 beats at
// consecutive wrapping addresses), and compared as words are consumed.
module tb_address_sequencer;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LW = 8;
    localparam int FW = DW + AW + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          enable_i = 1'b0;
    logic [FW-1:0] fifo_data_i = '0;
    logic          fifo_empty_i = 1'b1;
    logic          fifo_rd_en_o;
    logic          wr_valid_o;
    logic          wr_ready_i = 1'b0;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          busy_o;

    address_sequencer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .ADDR_STEP (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .fifo_data_i (fifo_data_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_rd_en_o(fifo_rd_en_o),
        .wr_valid_o  (wr_valid_o),
        .wr_ready_i  (wr_ready_i),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .last_o      (last_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected effect of consuming one FIFO word.
    typedef struct {
        bit            hdr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
        bit            burst_after;
    } eff_t;

    logic [FW-1:0] q_word[$];
    eff_t          q_eff[$];

    int n_vec = 0;
    int n_err = 0;
    int p_ready = 100;
    int p_enable = 100;
    int p_starve = 0;
    int n_pops = 0;
    int n_beats = 0;

    bit            model_burst = 1'b0;
    bit            pend_valid = 1'b0;
    eff_t          pend;
    bit            prev_acc = 1'b0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_single(input logic [AW-1:0] a, input logic [DW-1:0] d);
        eff_t e;
        e.hdr = 1'b0; e.addr = a; e.data = d; e.last = 1'b1; e.burst_after = 1'b0;
        q_word.push_back({1'b0, d, a});
        q_eff.push_back(e);
    endtask

    task automatic push_burst(input logic [AW-1:0] a, input logic [LW-1:0] len,
                              input bit directed, input logic [DW-1:0] base);
        eff_t          e;
        logic [DW-1:0] hd;
        logic [DW-1:0] d;
        logic [AW-1:0] junk_addr;
        logic          junk_flag;
        hd = $urandom();
        hd[LW-1:0] = len;
        e.hdr = 1'b1; e.addr = '0; e.data = '0; e.last = 1'b0; e.burst_after = 1'b1;
        q_word.push_back({1'b1, hd, a});
        q_eff.push_back(e);
        for (int i = 0; i <= int'(len); i++) begin
            d = directed ? base + DW'(i) : DW'($urandom());
            junk_addr = AW'($urandom());
            junk_flag = 1'($urandom_range(1));
            e.hdr = 1'b0;
            e.addr = AW'((int'(a) + i) % 256);
            e.data = d;
            e.last = (i == int'(len));
            e.burst_after = (i != int'(len));
            q_word.push_back({junk_flag, d, junk_addr});
            q_eff.push_back(e);
        end
    endtask

    // Present the FIFO head and randomized handshake inputs.
    task automatic drive();
        bit starve;
        wr_ready_i = ($urandom_range(99) < p_ready);
        enable_i   = ($urandom_range(99) < p_enable);
        starve     = ($urandom_range(99) < p_starve);
        fifo_empty_i = starve || (q_word.size() == 0);
        fifo_data_i  = (q_word.size() != 0) ? q_word[0] : FW'({$urandom(), $urandom()});
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit exp_rd;
        bit pop;
        @(negedge clk_i);
        exp_rd = rst_ni && enable_i && !fifo_empty_i && (!wr_valid_o || wr_ready_i);
        check("rd_en", 64'(fifo_rd_en_o), 64'(exp_rd));
        if (pend_valid) begin
            if (pend.hdr) begin
                check("hdr_idle_valid", 64'(wr_valid_o), 64'd0);
            end else begin
                check("beat_valid", 64'(wr_valid_o), 64'd1);
                check("beat_addr", 64'(addr_o), 64'(pend.addr));
                check("beat_data", 64'(data_o), 64'(pend.data));
                check("beat_last", 64'(last_o), 64'(pend.last));
            end
        end else if (prev_acc) begin
            check("acc_valid", 64'(wr_valid_o), 64'd0);
            check("acc_last", 64'(last_o), 64'd0);
        end else if (prev_stall) begin
            check("stall_valid", 64'(wr_valid_o), 64'd1);
            check("stall_addr", 64'(addr_o), 64'(prev_addr));
            check("stall_data", 64'(data_o), 64'(prev_data));
            check("stall_last", 64'(last_o), 64'(prev_last));
        end
        check("busy", 64'(busy_o), 64'(model_burst || wr_valid_o));
        prev_acc   = wr_valid_o && wr_ready_i;
        prev_stall = wr_valid_o && !wr_ready_i;
        prev_addr  = addr_o;
        prev_data  = data_o;
        prev_last  = last_o;
        if (wr_valid_o && wr_ready_i) n_beats++;
        pop = fifo_rd_en_o;
        @(posedge clk_i);
        pend_valid = 1'b0;
        if (pop) begin
            if (q_eff.size() == 0) begin
                check("pop_when_empty", 64'd1, 64'd0);
            end else begin
                pend = q_eff.pop_front();
                void'(q_word.pop_front());
                pend_valid = 1'b1;
                model_burst = pend.burst_after;
                n_pops++;
            end
        end
        #1 drive();
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((q_word.size() != 0 || wr_valid_o || pend_valid) && c < budget) begin
            step();
            c++;
        end
        check("drain_timeout", 64'(c >= budget), 64'd0);
    endtask

    task automatic wait_beat(input int budget);
        int b0 = n_beats;
        int c = 0;
        while (n_beats == b0 && c < budget) begin
            step();
            c++;
        end
        check("beat_timeout", 64'(c >= budget), 64'd0);
    endtask

    task automatic reset_checks();
        check("rst_valid", 64'(wr_valid_o), 64'd0);
        check("rst_addr", 64'(addr_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_last", 64'(last_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
    endtask

    task automatic set_knobs(input int r, input int e, input int s);
        p_ready = r; p_enable = e; p_starve = s;
    endtask

    initial begin
        int pops0;

        // Held in reset with a word waiting: nothing may be popped.
        set_knobs(100, 100, 0);
        push_single(8'h12, 32'hDEAD_BEEF);
        drive();
        repeat (2) @(posedge clk_i);
        #1 reset_checks();
        rst_ni = 1'b1;
        drive();

        // Single write.
        drain(50);
        check("single_idle_busy", 64'(busy_o), 64'd0);

        // Burst across the address wrap.
        push_burst(8'hFE, 8'd3, 1'b1, 32'h0000_00A0);
        drive();
        drain(50);

        // Backpressure on beat 2 of a 4-beat burst.
        push_burst(8'h20, 8'd3, 1'b0, '0);
        drive();
        wait_beat(50);
        set_knobs(0, 100, 0);
        drive();
        repeat (5) step();
        set_knobs(100, 100, 0);
        drain(50);

        // Back-to-back: 8 singles then a 2-beat burst, 11 pops in 11 cycles.
        for (int i = 0; i < 8; i++) push_single(AW'(i * 3), DW'($urandom()));
        push_burst(8'h80, 8'd1, 1'b0, '0);
        drive();
        pops0 = n_pops;
        repeat (11) step();
        check("b2b_pops", 64'(n_pops - pops0), 64'd11);
        drain(50);

        // Enable low, then FIFO starved, mid-burst.
        push_burst(8'h60, 8'd5, 1'b0, '0);
        drive();
        wait_beat(50);
        set_knobs(100, 0, 0);
        drive();
        repeat (3) step();
        set_knobs(100, 100, 100);
        drive();
        repeat (4) step();
        set_knobs(100, 100, 0);
        drain(100);

        // Maximum-length burst (256 beats) with light backpressure.
        set_knobs(80, 90, 10);
        push_burst(8'hC0, 8'hFF, 1'b0, '0);
        drive();
        drain(2000);

        // Randomized mix of singles and short bursts.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(2) == 0) push_burst(AW'($urandom()), LW'($urandom_range(6)), 1'b0, '0);
            else                        push_single(AW'($urandom()), DW'($urandom()));
            if (n % 20 == 0) set_knobs($urandom_range(30, 100), $urandom_range(50, 100), $urandom_range(0, 30));
        end
        drive();
        drain(20000);

        // Reset after beat 1 of a 4-beat burst.
        set_knobs(100, 100, 0);
        push_burst(8'h40, 8'd3, 1'b0, '0);
        drive();
        wait_beat(50);
        rst_ni = 1'b0;
        #1 reset_checks();
        q_word.delete();
        q_eff.delete();
        model_burst = 1'b0;
        pend_valid = 1'b0;
        prev_acc = 1'b0;
        prev_stall = 1'b0;
        push_single(8'h30, 32'h0000_0055);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        drive();
        pops0 = n_pops;
        step();
        check("post_rst_first_pop", 64'(n_pops - pops0), 64'd1);
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
